relu6_backward_stream: RTL and testbench

RELU6_BACKWARD_STREAM -- requirements
Module: relu6_backward_stream

---
 rtl/relu6_backward_stream.sv | 176 +++++++++++++++++
 tb/tb_relu6_backward_stream.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu6_backward_stream.sv
// ReLU6 backward pass over a streamed FP16 vector.
// dL/dx = dL/dy where 0 < x < 6.0 (bit-pattern compare), else +0.0.
// Two-stage valid/ready pipeline with dead/saturated element statistics.
module relu6_backward_stream #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      x_in,
    input  logic [15:0]      g_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [15:0]      g_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] dead_cnt,
    output logic [LEN_W-1:0] sat_cnt
);

    localparam int unsigned DW = 16;
    localparam logic [DW-1:0] SIX_FP16 = 16'h4600;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [LEN_W-1:0] r_remaining;

    logic             r_s1_valid;
    logic [DW-1:0]    r_s1_x;
    logic [DW-1:0]    r_s1_g;
    logic             r_s1_pass;

    logic             r_out_valid;
    logic [DW-1:0]    r_g_out;
    logic [LEN_W-1:0] r_dead_cnt;
    logic [LEN_W-1:0] r_sat_cnt;

    logic w_start_ok;
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_in_xfer;
    logic w_out_xfer;
    logic w_s1_move;
    logic w_pass_in;
    logic w_s1_nan;
    logic w_s1_sat;
    logic w_s1_dead;

    // Handshake and stage-advance terms; a stage moves if empty or its successor moves
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_s2_adv   = !r_out_valid || out_ready;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign in_ready   = (r_state == S_RUN) && (r_remaining != '0) && w_s1_adv;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;
    assign w_s1_move  = r_s1_valid && w_s2_adv;

    // Mask on raw bits: positive, non-zero, below 6.0 (subnormals pass, NaN/Inf fail)
    assign w_pass_in = !x_in[15] && (x_in != '0) && (x_in < SIX_FP16);

    // Classify masked elements: saturated (>= 6.0 incl. +Inf) vs dead (<= 0 or NaN)
    assign w_s1_nan  = (r_s1_x[14:10] == 5'h1F) && (r_s1_x[9:0] != 10'h000);
    assign w_s1_sat  = !r_s1_x[15] && (r_s1_x >= SIX_FP16) && !w_s1_nan;
    assign w_s1_dead = !r_s1_pass && !w_s1_sat;

    assign g_out     = r_g_out;
    assign out_valid = r_out_valid;
    assign dead_cnt  = r_dead_cnt;
    assign sat_cnt   = r_sat_cnt;
    assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) begin
                    w_state_nxt = (len != '0) ? S_RUN : S_DONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_remaining == '0) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_in_xfer && (r_remaining == LEN_W'(1))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_out_xfer && !r_s1_valid) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Elements still to be accepted for the current vector
    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
        end else if (w_start_ok) begin
            r_remaining <= len;
        end else if (w_in_xfer) begin
            r_remaining <= r_remaining - LEN_W'(1);
        end
    end

    // Stage 1: capture x, g and mask result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_g     <= '0;
            r_s1_pass  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= w_in_xfer;
            if (w_in_xfer) begin
                r_s1_x    <= x_in;
                r_s1_g    <= g_in;
                r_s1_pass <= w_pass_in;
            end
        end
    end

    // Stage 2: masked gradient output; holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_g_out     <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_g_out <= r_s1_pass ? r_s1_g : '0;
            end
        end
    end

    // Per-vector statistics, updated as elements move into stage 2
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dead_cnt <= '0;
            r_sat_cnt  <= '0;
        end else if (w_start_ok) begin
            r_dead_cnt <= '0;
            r_sat_cnt  <= '0;
        end else if (w_s1_move) begin
            if (w_s1_dead) begin
                r_dead_cnt <= r_dead_cnt + LEN_W'(1);
            end
            if (w_s1_sat) begin
                r_sat_cnt <= r_sat_cnt + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_relu6_backward_stream.sv
// Directed bench for relu6_backward_stream with hand-computed expectations.
module tb_relu6_backward_stream;

    localparam int unsigned LEN_W = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [15:0]      x_in;
    logic [15:0]      g_in;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      g_out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] dead_cnt;
    logic [LEN_W-1:0] sat_cnt;

    relu6_backward_stream #(.LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .x_in     (x_in),
        .g_in     (g_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .g_out    (g_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done),
        .dead_cnt (dead_cnt),
        .sat_cnt  (sat_cnt)
    );

    localparam logic [15:0] MASK_X [8] = '{16'hBC00, 16'h0000, 16'h8000, 16'h3C00,
                                           16'h4200, 16'h4600, 16'h4700, 16'h7C00};
    localparam logic [15:0] MASK_E [8] = '{16'h0000, 16'h0000, 16'h0000, 16'h3C00,
                                           16'h3C00, 16'h0000, 16'h0000, 16'h0000};

    int n_checks;
    int n_pass;
    logic [15:0] vx [16];
    logic [15:0] vg [16];
    logic [15:0] got_q [$];
    int in_cyc [$];
    int out_cyc [$];
    int pcyc;
    int occ;
    int n_done;
    int done_cyc;
    int bp_viol;
    int stab_viol;
    int stall_cnt;
    int rdy_mode;
    int ncyc;
    logic stall_prev;
    logic [15:0] held;

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Consumer ready: always high, or one cycle in three
    initial begin
        out_ready = 1'b1;
        ncyc = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            out_ready = (rdy_mode == 0) ? 1'b1 : ((ncyc % 3) == 0);
        end
    end

    // Monitor: samples just before each rising edge
    initial begin
        pcyc = 0; occ = 0; n_done = 0; done_cyc = 0;
        bp_viol = 0; stab_viol = 0; stall_cnt = 0;
        stall_prev = 1'b0; held = '0;
        forever begin
            @(negedge clk);
            #4;
            pcyc++;
            if (rst) begin
                occ = 0;
                stall_prev = 1'b0;
            end else begin
                if (occ == 2 && !out_ready && in_ready) bp_viol++;
                if (stall_prev && (!out_valid || g_out !== held)) stab_viol++;
                if (out_valid && !out_ready) stall_cnt++;
                stall_prev = out_valid && !out_ready;
                held = g_out;
                if (in_valid && in_ready) begin
                    occ++;
                    in_cyc.push_back(pcyc);
                end
                if (out_valid && out_ready) begin
                    occ--;
                    got_q.push_back(g_out);
                    out_cyc.push_back(pcyc);
                end
                if (done) begin
                    n_done++;
                    done_cyc = pcyc;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_obs();
        got_q.delete();
        in_cyc.delete();
        out_cyc.delete();
    endtask

    task automatic start_vec(input int n);
        start = 1'b1;
        len = LEN_W'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int first, input int n, output int to);
        int w;
        to = 0;
        for (int i = first; i < first + n; i++) begin
            in_valid = 1'b1;
            x_in = vx[i];
            g_in = vg[i];
            w = 0;
            #1;
            while (!in_ready && w < 200) begin
                @(negedge clk);
                #1;
                w++;
            end
            if (w >= 200) begin
                to++;
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n0;
        logic ok;
        n0 = n_done;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (n_done > n0) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        chk({tag, "_done_pulses"}, 32'(n_done - n0), 32'd1);
    endtask

    int to;
    int n_abort;
    int errs;

    initial begin
        n_checks = 0; n_pass = 0; rdy_mode = 0;
        rst = 1'b1; start = 1'b0; len = '0;
        x_in = '0; g_in = '0; in_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_g_out",     32'(g_out),     32'h0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_dead",      32'(dead_cnt),  32'd0);
        chk("rst_sat",       32'(sat_cnt),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Mask sweep
        for (int i = 0; i < 8; i++) begin
            vx[i] = MASK_X[i];
            vg[i] = 16'h3C00;
        end
        clear_obs();
        start_vec(8);
        feed(0, 8, to);
        chk("mask_feed_to", 32'(to), 32'd0);
        wait_done("mask");
        chk("mask_count", 32'(got_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < got_q.size()) chk($sformatf("mask_g%0d", i), 32'(got_q[i]), 32'(MASK_E[i]));
        end
        chk("mask_dead", 32'(dead_cnt), 32'd3);
        chk("mask_sat",  32'(sat_cnt),  32'd3);

        // Special values: positive subnormal passes, NaN is dead
        vx[0] = 16'h0001; vg[0] = 16'hC500;
        vx[1] = 16'h7E00; vg[1] = 16'h3C00;
        clear_obs();
        start_vec(2);
        feed(0, 2, to);
        chk("spec_feed_to", 32'(to), 32'd0);
        wait_done("spec");
        chk("spec_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            chk("spec_subnormal", 32'(got_q[0]), 32'hC500);
            chk("spec_nan",       32'(got_q[1]), 32'h0000);
        end
        chk("spec_dead", 32'(dead_cnt), 32'd1);
        chk("spec_sat",  32'(sat_cnt),  32'd0);

        // Latency and throughput
        for (int i = 0; i < 4; i++) begin
            vx[i] = 16'h3C00;
            vg[i] = 16'h2000 + 16'(i);
        end
        clear_obs();
        start_vec(4);
        feed(0, 4, to);
        chk("lat_feed_to", 32'(to), 32'd0);
        wait_done("lat");
        chk("lat_count", 32'(out_cyc.size()), 32'd4);
        if (out_cyc.size() == 4 && in_cyc.size() == 4) begin
            chk("lat_first",   32'(out_cyc[0] - in_cyc[0]), 32'd2);
            chk("lat_thru",    32'(out_cyc[3] - out_cyc[0]), 32'd3);
            chk("lat_in_thru", 32'(in_cyc[3] - in_cyc[0]), 32'd3);
            chk("lat_done",    32'(done_cyc - out_cyc[3]), 32'd1);
            chk("lat_g3",      32'(got_q[3]), 32'h2003);
        end

        // Backpressure with 1-in-3 consumer
        for (int i = 0; i < 16; i++) begin
            vx[i] = (i % 2 == 0) ? 16'h3C00 : 16'h4400;
            vg[i] = 16'h1000 + 16'(i);
        end
        clear_obs();
        bp_viol = 0; stab_viol = 0; stall_cnt = 0;
        rdy_mode = 1;
        start_vec(16);
        feed(0, 16, to);
        chk("bp_feed_to", 32'(to), 32'd0);
        wait_done("bp");
        rdy_mode = 0;
        chk("bp_count", 32'(got_q.size()), 32'd16);
        errs = 0;
        for (int i = 0; i < got_q.size(); i++) begin
            if (got_q[i] !== 16'h1000 + 16'(i)) errs++;
        end
        chk("bp_order",     32'(errs), 32'd0);
        chk("bp_stalled",   32'(stall_cnt > 0), 32'd1);
        chk("bp_stable",    32'(stab_viol), 32'd0);
        chk("bp_in_ready",  32'(bp_viol), 32'd0);
        @(negedge clk);

        // len == 0 goes straight to DONE
        clear_obs();
        start = 1'b1; len = '0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("len0_done",     32'(done),     32'd1);
        chk("len0_in_ready", 32'(in_ready), 32'd0);
        chk("len0_busy",     32'(busy),     32'd0);
        repeat (2) @(negedge clk);

        // start while busy is ignored
        vx[0] = 16'hBC00; vx[1] = 16'h3C00; vx[2] = 16'h4600; vx[3] = 16'h3C00;
        for (int i = 0; i < 4; i++) vg[i] = 16'h3800 + 16'(i);
        clear_obs();
        start_vec(4);
        feed(0, 2, to);
        start_vec(1);
        #1;
        chk("ign_busy", 32'(busy), 32'd1);
        @(negedge clk);
        feed(2, 2, errs);
        chk("ign_feed_to", 32'(to + errs), 32'd0);
        wait_done("ign");
        chk("ign_count", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) begin
            chk("ign_g1", 32'(got_q[1]), 32'h3801);
            chk("ign_g3", 32'(got_q[3]), 32'h3803);
        end
        chk("ign_dead", 32'(dead_cnt), 32'd1);
        chk("ign_sat",  32'(sat_cnt),  32'd1);

        // Reset mid-vector, then a fresh vector right after reset
        vx[0] = 16'hBC00;
        for (int i = 1; i < 8; i++) vx[i] = 16'h3C00;
        for (int i = 0; i < 8; i++) vg[i] = 16'h3C00;
        clear_obs();
        start_vec(8);
        feed(0, 3, to);
        chk("abort_feed_to", 32'(to), 32'd0);
        chk("abort_dead_pre", 32'(dead_cnt), 32'd1);
        n_abort = n_done;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_in_ready",  32'(in_ready),  32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_g_out",     32'(g_out),     32'h0);
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_dead",      32'(dead_cnt),  32'd0);
        chk("abort_sat",       32'(sat_cnt),   32'd0);
        @(negedge clk);
        chk("abort_no_done", 32'(n_done - n_abort), 32'd0);
        vx[0] = 16'h4200; vg[0] = 16'h3C00;
        vx[1] = 16'hC000; vg[1] = 16'h3C00;
        clear_obs();
        rst = 1'b0;
        start_vec(2);
        #1;
        chk("post_rst_busy", 32'(busy), 32'd1);
        feed(0, 2, to);
        chk("post_feed_to", 32'(to), 32'd0);
        wait_done("post");
        chk("post_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            chk("post_g0", 32'(got_q[0]), 32'h3C00);
            chk("post_g1", 32'(got_q[1]), 32'h0000);
        end
        chk("post_dead", 32'(dead_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
